clb_add_arb: RTL and testbench

//  Shares one clb_add instance among NREQ requesters. Round-robin arbitration picks a requester,

---
 rtl/clb_pkg.sv | 32 +++
 rtl/clb_add_arb_if.sv | 39 +++
 rtl/clb_tag_fifo.sv | 53 +++++
 rtl/clb_add_arb.sv | 140 ++++++++++++++
 tb/tb_clb_add_arb.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clb_pkg.sv
// Shared types and helpers for the clb adder arbiter and the clb_add datapath.
// Operand packing macro CLB_PACK_OPS is shared with clb_add.
`ifndef CLB_PKG_SV
`define CLB_PKG_SV

`define CLB_PACK_OPS(a, b) {(a), (b)}

package clb_pkg;

  localparam int unsigned CLB_WIDTH_DEF = 32;
  localparam int unsigned CLB_NREQ_DEF  = 4;
  localparam int unsigned CLB_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/clb_add_arb_if.sv
// Requester, adder and response signals of clb_add_arb.
// master = clients plus clb_add side, slave = the arbiter.
interface clb_add_arb_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned IDW = clb_pkg::clog2(NREQ);

  logic                  en;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  add_en;
  logic                  add_send;
  logic [2*WIDTH-1:0]    add_din;
  logic                  add_divld;
  logic                  add_rdy;
  logic [WIDTH:0]        add_dout;
  logic                  add_dovld;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_data;
  logic                  busy;
  logic                  err;

  modport master (
    output en, req_valid, req_a, req_b, add_rdy, add_dout, add_dovld,
    input  req_ready, add_en, add_send, add_din, add_divld,
           rsp_valid, rsp_id, rsp_data, busy, err
  );

  modport slave (
    input  en, req_valid, req_a, req_b, add_rdy, add_dout, add_dovld,
    output req_ready, add_en, add_send, add_din, add_divld,
           rsp_valid, rsp_id, rsp_data, busy, err
  );

endinterface

// File: rtl/clb_tag_fifo.sv
// Synchronous FIFO of requester IDs for ops in flight in the adder.
// Simultaneous push and pop are accepted even when full.
module clb_tag_fifo #(
  parameter int unsigned IDW   = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = clb_pkg::clog2(DEPTH),
  localparam int unsigned CW   = clb_pkg::clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [IDW-1:0] din,
  output logic [IDW-1:0] head,
  output logic [CW-1:0]  count,
  output logic           empty,
  output logic           full
);

  logic [IDW-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/clb_add_arb.sv
// Round-robin arbiter sharing one clb_add among NREQ requesters, with in-order result return.
// Define CLB_ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin group.
module clb_add_arb import clb_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  clb_add_arb_if.slave bus
);

  localparam int unsigned IDW = clog2(NREQ);
  localparam int unsigned CW  = clog2(DEPTH) + 1;

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic            busy_q;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  winner;
  logic            win_found;
  logic [NREQ-1:0] cand;
  int unsigned     idx;
  logic            any_req;
  logic            grant_ok;
  logic            xfer;
  logic            pop;
  logic [CW-1:0]   cnt;
  logic            fifo_empty;
  logic            fifo_full;
  logic [IDW-1:0]  fifo_head;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  assign any_req  = |bus.req_valid;
  assign grant_ok = ~rst & bus.en & bus.add_rdy & ~fifo_full &
                    ((state == IDLE) | (state == RUN));
  assign xfer     = grant_ok & win_found;
  assign pop      = bus.add_dovld & ~fifo_empty;

  // First candidate at or after the rr pointer wins.
  always_comb begin
    cand      = bus.req_valid;
    winner    = '0;
    win_found = 1'b0;
    idx       = 0;
`ifdef CLB_ARB_PRIO0_EN
    cand[0] = 1'b0;
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!win_found && cand[idx]) begin
        winner    = IDW'(idx);
        win_found = 1'b1;
      end
    end
`ifdef CLB_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      winner    = '0;
      win_found = 1'b1;
    end
`endif
  end

  assign bus.req_ready = xfer ? (NREQ'(1) << winner) : '0;
  assign win_a         = bus.req_a[32'(winner)*WIDTH +: WIDTH];
  assign win_b         = bus.req_b[32'(winner)*WIDTH +: WIDTH];

  // Adder stays enabled while in-flight ops drain.
  assign bus.busy     = busy_q;
  assign bus.add_en   = bus.en | busy_q;
  assign bus.add_send = bus.add_en;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.en && any_req) state_nxt = RUN;
      RUN: begin
        if (!bus.en)                      state_nxt = DRAIN;
        else if (!any_req && cnt == '0)   state_nxt = IDLE;
      end
      DRAIN: begin
        if (cnt == '0)   state_nxt = IDLE;
        else if (bus.en) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
`ifdef CLB_ARB_PRIO0_EN
      if (xfer && winner != '0)
`else
      if (xfer)
`endif
        rr_ptr <= (32'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
    end
  end

  // Issue register and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.add_divld <= 1'b0;
      bus.add_din   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.add_divld <= xfer;
      if (xfer) bus.add_din <= `CLB_PACK_OPS(win_a, win_b);
      bus.rsp_valid <= pop;
      if (pop) begin
        bus.rsp_id   <= fifo_head;
        bus.rsp_data <= bus.add_dout;
      end
      if (bus.add_dovld && fifo_empty) bus.err <= 1'b1;
    end
  end

  clb_tag_fifo #(.IDW(IDW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .pop   (pop),
    .din   (winner),
    .head  (fifo_head),
    .count (cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_clb_add_arb.sv
// Directed bench for clb_add_arb; the bench plays both the requesters and the clb_add adder.
module tb_clb_add_arb;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clb_add_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  clb_add_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int unsigned     id;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [32:0]     sum;
    logic [NREQ-1:0] rdy;
  } vec_t;

  vec_t        vecs[5];
  int          passed = 0;
  int          total  = 0;
  int          gq[$];
  int          rq[$];
  logic [32:0] dq[$];
  logic        model_on = 1'b0;
  int unsigned lat = 3;
  logic        pipe_v[4];
  logic [32:0] pipe_d[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // One clock: record grants before the edge, responses and adder model after it.
  task automatic step();
    logic [63:0] din_s;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) gq.push_back(i);
    @(posedge clk);
    #1;
    if (bus.rsp_valid) begin
      rq.push_back(int'(bus.rsp_id));
      dq.push_back(bus.rsp_data);
    end
    if (model_on) begin
      bus.add_dovld = pipe_v[lat-1];
      bus.add_dout  = pipe_d[lat-1];
      for (int s = int'(lat) - 1; s > 0; s--) begin
        pipe_v[s] = pipe_v[s-1];
        pipe_d[s] = pipe_d[s-1];
      end
      din_s     = bus.add_din;
      pipe_v[0] = bus.add_divld;
      pipe_d[0] = {1'b0, din_s[63:32]} + {1'b0, din_s[31:0]};
    end
  endtask

  task automatic do_reset();
    model_on      = 1'b0;
    bus.add_dovld = 1'b0;
    bus.add_dout  = '0;
    bus.req_valid = '0;
    for (int s = 0; s < 4; s++) begin
      pipe_v[s] = 1'b0;
      pipe_d[s] = '0;
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    gq.delete();
    rq.delete();
    dq.delete();
  endtask

  task automatic set_ops(input int unsigned id, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[id*WIDTH +: WIDTH] = a;
    bus.req_b[id*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_g[6];
    int          exp_id3[5];
    logic [32:0] exp_d3[5];

    vecs[0] = '{0, 32'h0000_00D0, 32'h0000_000E, 33'h0_0000_00DE, 4'b0001};
    vecs[1] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 4'b0100};
    vecs[2] = '{1, 32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, 4'b0010};
    vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, 4'b1000};
    vecs[4] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 4'b0010};

    bus.en      = 1'b0;
    bus.add_rdy = 1'b1;
    bus.req_a   = '0;
    bus.req_b   = '0;
    do_reset();

    // Reset state
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst divld", 64'(bus.add_divld), 64'd0);
    chk("rst din", bus.add_din, 64'd0);
    chk("rst err", 64'(bus.err), 64'd0);
    chk("rst add_en", 64'(bus.add_en), 64'd0);

    // Single transactions from the vector table
    bus.en = 1'b1;
    foreach (vecs[v]) begin
      bus.req_a = '0;
      bus.req_b = '0;
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      bus.req_valid = NREQ'(1) << vecs[v].id;
      #1;
      chk("t1 req_ready", 64'(bus.req_ready), 64'(vecs[v].rdy));
      step();
      bus.req_valid = '0;
      chk("t1 divld", 64'(bus.add_divld), 64'd1);
      chk("t1 din", bus.add_din, {vecs[v].a, vecs[v].b});
      bus.add_dovld = 1'b1;
      bus.add_dout  = {1'b0, vecs[v].a} + {1'b0, vecs[v].b};
      step();
      bus.add_dovld = 1'b0;
      chk("t1 rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t1 rsp_id", 64'(bus.rsp_id), 64'(vecs[v].id));
      chk("t1 rsp_data", 64'(bus.rsp_data), 64'(vecs[v].sum));
      step();
      step();
    end

    // All four requesting, adder latency 3
    do_reset();
    bus.en = 1'b1;
    set_ops(0, 32'h100, 32'h1);
    set_ops(1, 32'h200, 32'h2);
    set_ops(2, 32'h300, 32'h3);
    set_ops(3, 32'h400, 32'h4);
    model_on      = 1'b1;
    lat           = 3;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 40 && gq.size() < 5; c++) step();
    bus.req_valid = '0;
    for (int c = 0; c < 40 && rq.size() < 5; c++) step();
    chk("t3 grants", 64'(gq.size()), 64'd5);
    chk("t3 rsps", 64'(rq.size()), 64'd5);
    exp_id3 = '{0, 1, 2, 3, 0};
    exp_d3  = '{33'h101, 33'h202, 33'h303, 33'h404, 33'h101};
    for (int i = 0; i < 5; i++) begin
      if (i < gq.size()) chk("t3 grant order", 64'(gq[i]), 64'(exp_id3[i]));
      if (i < rq.size()) chk("t3 rsp id", 64'(rq[i]), 64'(exp_id3[i]));
      if (i < dq.size()) chk("t3 rsp data", 64'(dq[i]), 64'(exp_d3[i]));
    end
    for (int c = 0; c < 20 && bus.busy; c++) step();
    chk("t3 idle", 64'(bus.busy), 64'd0);

    // Results withheld: FIFO full stops grants; one return frees a slot a cycle later
    do_reset();
    bus.en        = 1'b1;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 10; c++) step();
    chk("t4 grants", 64'(gq.size()), 64'd4);
    chk("t4 ready full", 64'(bus.req_ready), 64'd0);
    bus.add_dovld = 1'b1;
    bus.add_dout  = 33'h0_0000_0ABC;
    #1;
    chk("t4 ready on pop", 64'(bus.req_ready), 64'd0);
    step();
    bus.add_dovld = 1'b0;
    chk("t4 rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t4 rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("t4 rsp_data", 64'(bus.rsp_data), 64'h0ABC);
    chk("t4 ready after pop", 64'(bus.req_ready), 64'b0001);
    step();
    chk("t4 grant count", 64'(gq.size()), 64'd5);

    // Drop en with two ops in flight
    do_reset();
    bus.en        = 1'b1;
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 10 && gq.size() < 2; c++) step();
    bus.req_valid = 4'hF;
    bus.en        = 1'b0;
    #1;
    chk("t5 no grant", 64'(bus.req_ready), 64'd0);
    step();
    chk("t5 busy drain", 64'(bus.busy), 64'd1);
    chk("t5 add_en held", 64'(bus.add_en), 64'd1);
    bus.add_dovld = 1'b1;
    bus.add_dout  = 33'h1;
    step();
    bus.add_dovld = 1'b1;
    bus.add_dout  = 33'h2;
    chk("t5 rsp1 id", 64'(bus.rsp_id), 64'd1);
    chk("t5 busy mid", 64'(bus.busy), 64'd1);
    step();
    bus.add_dovld = 1'b0;
    chk("t5 rsp2 valid", 64'(bus.rsp_valid), 64'd1);
    chk("t5 rsp2 id", 64'(bus.rsp_id), 64'd3);
    step();
    chk("t5 busy off", 64'(bus.busy), 64'd0);
    chk("t5 add_en off", 64'(bus.add_en), 64'd0);
    chk("t5 grants", 64'(gq.size()), 64'd2);
    bus.req_valid = '0;

    // Reset with three ops in flight, then a stray result
    do_reset();
    bus.en        = 1'b1;
    bus.req_valid = 4'hF;
    for (int c = 0; c < 10 && gq.size() < 3; c++) step();
    bus.req_valid = '0;
    bus.en        = 1'b0;
    rst           = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 busy", 64'(bus.busy), 64'd0);
    chk("t6 divld", 64'(bus.add_divld), 64'd0);
    chk("t6 din", bus.add_din, 64'd0);
    chk("t6 rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t6 err", 64'(bus.err), 64'd0);
    bus.add_dovld = 1'b1;
    bus.add_dout  = 33'h5;
    step();
    bus.add_dovld = 1'b0;
    chk("t6 no rsp", 64'(bus.rsp_valid), 64'd0);
    chk("t6 err set", 64'(bus.err), 64'd1);
    step();
    chk("t6 err sticky", 64'(bus.err), 64'd1);

    // Requesters 0 and 1 always valid
    do_reset();
    bus.en        = 1'b1;
    model_on      = 1'b1;
    lat           = 1;
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 30 && gq.size() < 6; c++) step();
    bus.req_valid = '0;
`ifdef CLB_ARB_PRIO0_EN
    exp_g = '{0, 0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1, 0, 1};
`endif
    chk("t7 grants", 64'(gq.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) chk("t7 grant order", 64'(gq[i]), 64'(exp_g[i]));
    for (int c = 0; c < 20 && bus.busy; c++) step();
    chk("t7 idle", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
